// File: rtl/sw_input_port_if.sv
// rtl/sw_input_port_if.sv - CPU-side read bus of the switch input port
interface sw_input_port_if;
    logic        rd;
    logic [15:0] rd_data;
    logic        data_valid;
    logic        overrun;

    modport master (output rd, input rd_data, input data_valid, input overrun);
    modport slave  (input rd, output rd_data, output data_valid, output overrun);
endinterface

// File: rtl/sw_input_port.sv
// rtl/sw_input_port.sv - debounced key press captures slide switches into a CPU-readable holding register
// Define SW_SIGN_EXT_EN to sign-extend the captured switches instead of zero-extending them.
module sw_input_port #(
    parameter int SW_WIDTH        = 10,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                key_n,
    input  logic [SW_WIDTH-1:0] sw,
    sw_input_port_if.slave      bus
);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        RELEASE_WAIT
    } state_t;

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic                key_meta_q, key_meta_d;
    logic                key_s_q, key_s_d;
    logic [SW_WIDTH-1:0] sw_meta_q, sw_meta_d;
    logic [SW_WIDTH-1:0] sw_s_q, sw_s_d;
    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                capture_q, capture_d;
    logic [15:0]         rd_data_q, rd_data_d;
    logic                data_valid_q, data_valid_d;
    logic                overrun_q, overrun_d;
    logic [15:0]         cap_val;

    always_comb begin
        cap_val = '0;
`ifdef SW_SIGN_EXT_EN
        cap_val = {16{sw_s_q[SW_WIDTH-1]}};
`endif
        cap_val[SW_WIDTH-1:0] = sw_s_q;
    end

    always_comb begin
        key_meta_d   = key_n;
        key_s_d      = key_meta_q;
        sw_meta_d    = sw;
        sw_s_d       = sw_meta_q;
        state_d      = state_q;
        cnt_d        = cnt_q;
        capture_d    = 1'b0;
        rd_data_d    = rd_data_q;
        data_valid_d = data_valid_q;
        overrun_d    = overrun_q;

        // The counter holds how many consecutive samples of the new level have been seen.
        case (state_q)
            IDLE: begin
                if (!key_s_q) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        state_d   = HELD;
                        cnt_d     = '0;
                        capture_d = 1'b1;
                    end else begin
                        state_d = PRESS_WAIT;
                        cnt_d   = CNT_ONE;
                    end
                end
            end
            PRESS_WAIT: begin
                if (key_s_q) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = HELD;
                    cnt_d     = '0;
                    capture_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            HELD: begin
                if (key_s_q) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        state_d = RELEASE_WAIT;
                        cnt_d   = CNT_ONE;
                    end
                end
            end
            RELEASE_WAIT: begin
                if (!key_s_q) begin
                    state_d = HELD;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        // A capture takes priority over a read; a read in the same cycle consumes the old value.
        if (capture_q) begin
            rd_data_d    = cap_val;
            data_valid_d = 1'b1;
            if (bus.rd) begin
                overrun_d = 1'b0;
            end else if (data_valid_q) begin
                overrun_d = 1'b1;
            end
        end else if (bus.rd && data_valid_q) begin
            data_valid_d = 1'b0;
            overrun_d    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            key_meta_q   <= 1'b1;
            key_s_q      <= 1'b1;
            sw_meta_q    <= '0;
            sw_s_q       <= '0;
            state_q      <= IDLE;
            cnt_q        <= '0;
            capture_q    <= 1'b0;
            rd_data_q    <= '0;
            data_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            key_meta_q   <= key_meta_d;
            key_s_q      <= key_s_d;
            sw_meta_q    <= sw_meta_d;
            sw_s_q       <= sw_s_d;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            capture_q    <= capture_d;
            rd_data_q    <= rd_data_d;
            data_valid_q <= data_valid_d;
            overrun_q    <= overrun_d;
        end
    end

    assign bus.rd_data    = rd_data_q;
    assign bus.data_valid = data_valid_q;
    assign bus.overrun    = overrun_q;

endmodule

// File: tb/tb_sw_input_port.sv
// tb/tb_sw_input_port.sv - randomized self-checking bench for sw_input_port against a run-length reference model
module tb_sw_input_port;

    localparam int SW_WIDTH = 10;
    localparam int DC       = 4;

    logic                clk = 1'b0;
    logic                reset;
    logic                key_n;
    logic [SW_WIDTH-1:0] sw;

    always #5 clk = ~clk;

    sw_input_port_if bus ();

    sw_input_port #(
        .SW_WIDTH        (SW_WIDTH),
        .DEBOUNCE_CYCLES (DC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .key_n (key_n),
        .sw    (sw),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // reference model: delayed samples, accepted key level and run length of the opposite level
    logic                m_k1, m_k2;
    logic [SW_WIDTH-1:0] m_s1, m_s2;
    logic                m_acc;
    int                  m_run;
    logic                m_cap;
    logic [15:0]         m_data;
    logic                m_valid, m_ovr;
    bit                  model_on = 1'b0;

    task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] ext(input logic [SW_WIDTH-1:0] v);
        logic [15:0] r;
`ifdef SW_SIGN_EXT_EN
        r = {16{v[SW_WIDTH-1]}};
`else
        r = '0;
`endif
        r[SW_WIDTH-1:0] = v;
        return r;
    endfunction

    task automatic model_step();
        logic new_cap;
        if (reset) begin
            m_k1 = 1'b1; m_k2 = 1'b1; m_s1 = '0; m_s2 = '0;
            m_acc = 1'b1; m_run = 0; m_cap = 1'b0;
            m_data = '0; m_valid = 1'b0; m_ovr = 1'b0;
            model_on = 1'b1;
        end else begin
            if (m_cap) begin
                m_ovr   = m_valid && !bus.rd;
                m_data  = ext(m_s2);
                m_valid = 1'b1;
            end else if (bus.rd && m_valid) begin
                m_valid = 1'b0;
                m_ovr   = 1'b0;
            end
            new_cap = 1'b0;
            m_run = (m_k2 != m_acc) ? m_run + 1 : 0;
            if (m_run == DC) begin
                m_acc   = m_k2;
                m_run   = 0;
                new_cap = (m_k2 == 1'b0);
            end
            m_cap = new_cap;
            m_k2 = m_k1; m_k1 = key_n;
            m_s2 = m_s1; m_s1 = sw;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        if (model_on) begin
            check_val("rd_data", bus.rd_data, m_data);
            check_val("data_valid", {15'b0, bus.data_valid}, {15'b0, m_valid});
            check_val("overrun", {15'b0, bus.overrun}, {15'b0, m_ovr});
        end
    endtask

    task automatic press(input logic [SW_WIDTH-1:0] v, input int hold, input int rel);
        sw    = v;
        key_n = 1'b0;
        repeat (hold) tick();
        key_n = 1'b1;
        repeat (rel) tick();
    endtask

    task automatic read_pulse();
        bus.rd = 1'b1;
        tick();
        bus.rd = 1'b0;
    endtask

    logic [15:0] exp_2a5;
    int          lat;

    initial begin
`ifdef SW_SIGN_EXT_EN
        exp_2a5 = 16'hFEA5;
`else
        exp_2a5 = 16'h02A5;
`endif
        reset  = 1'b1;
        key_n  = 1'b0;
        sw     = 10'h3FF;
        bus.rd = 1'b0;
        tick();
        tick();
        check_val("rst_rd_data", bus.rd_data, 16'h0000);
        check_val("rst_valid", {15'b0, bus.data_valid}, 16'h0);
        check_val("rst_overrun", {15'b0, bus.overrun}, 16'h0);
        reset = 1'b0;
        key_n = 1'b1;
        repeat (20) tick();
        check_val("no_cap_after_reset", {15'b0, bus.data_valid}, 16'h0);

        // clean press: measure key fall to data_valid latency
        sw = 10'h2A5;
        repeat (3) tick();
        key_n = 1'b0;
        lat   = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (bus.data_valid && lat == 0) lat = i;
        end
        check_val("press_latency", 16'(lat), 16'd7);
        check_val("clean_data", bus.rd_data, exp_2a5);
        key_n = 1'b1;
        repeat (15) tick();
        check_val("single_capture", {15'b0, bus.overrun}, 16'h0);
        read_pulse();
        check_val("read_clears_valid", {15'b0, bus.data_valid}, 16'h0);

        // bounces shorter than the debounce window
        repeat (3) begin
            key_n = 1'b0; tick(); tick();
            key_n = 1'b1; tick(); tick();
        end
        repeat (20) tick();
        check_val("bounce_no_capture", {15'b0, bus.data_valid}, 16'h0);

        // overrun then read
        press(10'h011, 10, 12);
        press(10'h022, 10, 12);
        check_val("ovr_data", bus.rd_data, 16'h0022);
        check_val("ovr_set", {15'b0, bus.overrun}, 16'h1);
        read_pulse();
        check_val("ovr_read_valid", {15'b0, bus.data_valid}, 16'h0);
        check_val("ovr_read_clear", {15'b0, bus.overrun}, 16'h0);
        check_val("ovr_read_hold", bus.rd_data, 16'h0022);

        // read coincident with a capture while valid
        press(10'h011, 10, 12);
        sw    = 10'h1F0;
        key_n = 1'b0;
        repeat (6) tick();
        bus.rd = 1'b1;
        tick();
        bus.rd = 1'b0;
        check_val("sim_data", bus.rd_data, 16'h01F0);
        check_val("sim_valid", {15'b0, bus.data_valid}, 16'h1);
        check_val("sim_overrun", {15'b0, bus.overrun}, 16'h0);
        repeat (4) tick();
        key_n = 1'b1;
        repeat (12) tick();
        read_pulse();

        // reset in the middle of a debounce
        key_n = 1'b0;
        repeat (4) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        key_n = 1'b1;
        repeat (10) tick();
        check_val("mid_reset_valid", {15'b0, bus.data_valid}, 16'h0);

        // randomized presses, bounces and reads
        for (int it = 0; it < 80; it++) begin
            sw    = SW_WIDTH'($urandom);
            key_n = 1'b0;
            repeat ($urandom_range(1, 10)) begin
                bus.rd = ($urandom_range(0, 3) == 0);
                tick();
            end
            key_n = 1'b1;
            repeat ($urandom_range(1, 10)) begin
                bus.rd = ($urandom_range(0, 3) == 0);
                tick();
            end
        end
        bus.rd = 1'b0;
        repeat (10) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sw_input_port.md
Name: sw_input_port

Overview:
Memory-mapped input port that carries board data toward the CPU, the input counterpart of the datapath-to-seven-segment output path. It synchronizes and debounces an active-low push key. On each clean press it captures the slide switches into a 16-bit holding register and raises a sticky valid flag. The CPU reads the register with a one-cycle read strobe, which consumes the value.

Parameters:
SW_WIDTH, 10, number of switch bits captured (1..16).
DEBOUNCE_CYCLES, 4, consecutive stable synchronized samples required to accept a key level change (>=1).

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high; sampled on rising edge of clk
key_n  input  1  raw active-low push key (0 = pressed), asynchronous to clk
sw  input  SW_WIDTH  raw slide switches, asynchronous, assumed stable while key is pressed
rd  input  1  CPU read strobe, one cycle per read
rd_data  output  16  holding register contents
data_valid  output  1  holding register holds an unread capture
overrun  output  1  sticky: a capture overwrote an unread value

Behaviour:
- Reset (synchronous, active-high): rd_data=16'h0000, data_valid=0, overrun=0. Debounce FSM goes to IDLE, debounce counter=0. Both synchronizer flops load 1 (key released). Reset asserted mid-debounce or mid-capture discards everything.
- Synchronizer: two flops on key_n; only the second flop output (key_s) is used. sw is sampled by a two-flop synchronizer (sw_s) in parallel.
- Debounce FSM, 4 states:
  - IDLE (released): key_s=0 -> PRESS_WAIT, counter=1.
  - PRESS_WAIT: key_s=0 and counter==DEBOUNCE_CYCLES-1 -> HELD and assert internal capture for exactly one cycle. key_s=0 otherwise -> counter+1. key_s=1 -> IDLE, counter=0.
  - HELD: key_s=1 -> RELEASE_WAIT, counter=1.
  - RELEASE_WAIT: key_s=1 and counter==DEBOUNCE_CYCLES-1 -> IDLE. key_s=0 -> HELD, counter=0.
  - DEBOUNCE_CYCLES=1: the transition happens on the first sample seen in the new level.
- Latency: key_n falling edge to data_valid=1 is 2 (sync) + DEBOUNCE_CYCLES + 1 clocks. One press yields exactly one capture, regardless of hold time. Bounces shorter than DEBOUNCE_CYCLES yield none.
- Capture cycle: rd_data <= {zeros, sw_s} (16-bit zero extension) and data_valid <= 1. If data_valid was already 1 and no rd occurs this cycle: overrun <= 1.
- Read: rd=1 with data_valid=1 -> data_valid <= 0 and overrun <= 0 next edge. rd_data is unchanged by reads and holds its last value.
- rd=1 with data_valid=0: no state change.
- Same-cycle capture and rd: the capture wins. rd_data takes the new value, data_valid stays 1, overrun <= 0 (the old value was consumed).
- All outputs are registered; no combinational path from rd to any output.

Optional Feature:
SW_SIGN_EXT_EN — defined: capture sign-extends sw_s from bit SW_WIDTH-1 to 16 bits, matching the sximm convention. Undefined: zero extension as above. No other behaviour changes.

Test Plan:
- Reset: assert reset 2 cycles with key_n=0, sw=10'h3FF -> rd_data=0000, data_valid=0, overrun=0; no capture until key_n returns high and is pressed again.
- Clean press: sw=10'h2A5, key_n low 20 cycles, DEBOUNCE_CYCLES=4 -> data_valid rises exactly 7 clocks after the key_n fall; rd_data=16'h02A5; only one capture during the hold.
- Bounce: key_n toggles low for 2 cycles, then high 2 cycles, 3 times, then stays high -> data_valid stays 0 and FSM returns to IDLE.
- Read and overrun: capture 16'h0011, press again with sw=10'h022 without rd -> rd_data=0022, overrun=1. Pulse rd -> data_valid=0 and overrun=0 next cycle, rd_data stays 0022.
- Simultaneous: rd asserted in the capture cycle of a second press (sw=10'h1F0) while data_valid=1 -> rd_data=01F0, data_valid=1, overrun=0.
- With SW_SIGN_EXT_EN: sw=10'h2A5 capture -> rd_data=16'hFEA5; sw=10'h0A5 -> 16'h00A5.
